fetch_unit: RTL and testbench

//  Instruction-fetch stage feeding the IF/ID pipeline register. Owns the fetch PC and

---
 rtl/fetch_unit.sv | 102 ++++++++++
 tb/tb_fetch_unit.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, runs a single-outstanding req/ack
// memory port, and holds one fetched instruction until decode takes it.
module fetch_unit #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter logic [31:0] BUBBLE_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        id_ready,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        validF,
    output logic [31:0] pcF,
    output logic [31:0] instrF
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        DISCARD = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] fetch_pc;
    logic        vld_p0;
    logic [31:0] pc_p0;
    logic [31:0] instr_p0;
    logic        consume;
    logic        capture;
    logic [31:0] redirect_tgt;

    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return pc & ~32'h0000_0003;
    endfunction

    // Sequential fetch simply wraps at the top of the address space.
    function automatic logic [31:0] inc_pc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

    assign consume      = vld_p0 & id_ready;
    assign capture      = (state == REQ) & imem_ack & ~redirect;
    assign redirect_tgt = align_pc(redirect_pc);

    // Control: FSM, fetch PC and buffer-valid flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
            vld_p0   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (redirect) begin
                        fetch_pc <= redirect_tgt;
                        vld_p0   <= 1'b0;
                    end else if (!vld_p0 || consume) begin
                        state <= REQ;
                        if (consume) vld_p0 <= 1'b0;
                    end
                end
                REQ: begin
                    if (redirect) begin
                        fetch_pc <= redirect_tgt;
                        vld_p0   <= 1'b0;
                        state    <= imem_ack ? IDLE : DISCARD;
                    end else if (imem_ack) begin
                        fetch_pc <= inc_pc(fetch_pc);
                        vld_p0   <= 1'b1;
                        state    <= IDLE;
                    end
                end
                DISCARD: begin
                    // The stale response only retires the access; its data is never kept.
                    if (redirect) fetch_pc <= redirect_tgt;
                    if (imem_ack) state <= IDLE;
                    vld_p0 <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Data: instruction buffer, qualified by vld_p0
    always_ff @(posedge clk) begin
        if (capture) begin
            pc_p0    <= fetch_pc;
            instr_p0 <= imem_rdata;
        end
    end

    assign imem_req  = (state != IDLE);
    assign imem_addr = fetch_pc;
    assign validF    = vld_p0;
    assign pcF       = vld_p0 ? pc_p0 : 32'h0000_0000;
    assign instrF    = vld_p0 ? instr_p0 : BUBBLE_INSTR;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a per-cycle vector table plus hand sequences for
// asynchronous reset, two-edge fetch latency and steady-state streaming.
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        id_ready;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        validF;
    logic [31:0] pcF;
    logic [31:0] instrF;

    int errors = 0;
    int checks = 0;

    fetch_unit #(
        .RESET_PC    (32'h0000_0000),
        .BUBBLE_INSTR(32'h0000_0000)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .id_ready   (id_ready),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .validF     (validF),
        .pcF        (pcF),
        .instrF     (instrF)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        redir;
        logic [31:0] rpc;
        logic        idr;
        logic        ack;
        logic [31:0] rdata;
        logic        req;
        logic [31:0] addr;
        logic        v;
        logic [31:0] pc;
        logic [31:0] instr;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic r, input logic rd, input logic [31:0] rp,
                                input logic ir, input logic ak, input logic [31:0] dat,
                                input logic eq, input logic [31:0] ea, input logic ev,
                                input logic [31:0] ep, input logic [31:0] ei);
        vec_t t;
        t.rst = r;   t.redir = rd; t.rpc = rp;  t.idr = ir; t.ack = ak; t.rdata = dat;
        t.req = eq;  t.addr = ea;  t.v = ev;    t.pc = ep;  t.instr = ei;
        return t;
    endfunction

    task automatic check_out(input string name, input logic eq, input logic [31:0] ea,
                             input logic ev, input logic [31:0] ep, input logic [31:0] ei);
        checks++;
        if ({imem_req, imem_addr, validF, pcF, instrF} !== {eq, ea, ev, ep, ei}) begin
            errors++;
            $display("FAIL %s: got req=%0b addr=%h v=%0b pc=%h instr=%h, expected req=%0b addr=%h v=%0b pc=%h instr=%h",
                     name, imem_req, imem_addr, validF, pcF, instrF, eq, ea, ev, ep, ei);
        end
    endtask

    initial begin
        logic        mv;
        logic        mreq;
        logic [31:0] maddr;
        logic [31:0] mpc;

        // rst redir rpc idr ack rdata | req addr v pc instr
        tbl.push_back(mk(1,0,32'h0,1,1,32'h13,        0,32'h0,0,32'h0,32'h0));
        tbl.push_back(mk(0,0,32'h0,1,1,32'h13,        0,32'h0,0,32'h0,32'h0));
        tbl.push_back(mk(0,0,32'h0,1,1,32'h13,        1,32'h0,0,32'h0,32'h0));
        tbl.push_back(mk(0,0,32'h0,1,1,32'h13,        0,32'h4,1,32'h0,32'h13));
        tbl.push_back(mk(0,0,32'h0,1,1,32'h13,        1,32'h4,0,32'h0,32'h0));
        tbl.push_back(mk(0,0,32'h0,1,1,32'h13,        0,32'h8,1,32'h4,32'h13));
        tbl.push_back(mk(0,0,32'h0,1,0,32'h0,         1,32'h8,0,32'h0,32'h0));
        tbl.push_back(mk(0,0,32'h0,1,0,32'h0,         1,32'h8,0,32'h0,32'h0));
        tbl.push_back(mk(0,0,32'h0,1,0,32'h0,         1,32'h8,0,32'h0,32'h0));
        tbl.push_back(mk(0,0,32'h0,1,1,32'h0000AAAA,  1,32'h8,0,32'h0,32'h0));
        tbl.push_back(mk(0,0,32'h0,1,0,32'h0,         0,32'hC,1,32'h8,32'h0000AAAA));
        tbl.push_back(mk(0,1,32'h100,1,0,32'h0,       1,32'hC,0,32'h0,32'h0));
        tbl.push_back(mk(0,0,32'h0,1,0,32'h0,         1,32'h100,0,32'h0,32'h0));
        tbl.push_back(mk(0,0,32'h0,1,1,32'hDEADBEEF,  1,32'h100,0,32'h0,32'h0));
        tbl.push_back(mk(0,0,32'h0,1,0,32'h0,         0,32'h100,0,32'h0,32'h0));
        tbl.push_back(mk(0,0,32'h0,1,1,32'h11111111,  1,32'h100,0,32'h0,32'h0));
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(0,0,32'h0,0,0,32'h0,     0,32'h104,1,32'h100,32'h11111111));
        tbl.push_back(mk(0,0,32'h0,1,0,32'h0,         0,32'h104,1,32'h100,32'h11111111));
        tbl.push_back(mk(0,0,32'h0,1,1,32'h22222222,  1,32'h104,0,32'h0,32'h0));
        tbl.push_back(mk(0,1,32'h203,1,0,32'h0,       0,32'h108,1,32'h104,32'h22222222));
        tbl.push_back(mk(0,0,32'h0,1,0,32'h0,         0,32'h200,0,32'h0,32'h0));
        tbl.push_back(mk(0,0,32'h0,1,1,32'h33333333,  1,32'h200,0,32'h0,32'h0));
        tbl.push_back(mk(0,0,32'h0,1,0,32'h0,         0,32'h204,1,32'h200,32'h33333333));
        tbl.push_back(mk(0,1,32'hFFFFFFFC,1,1,32'h44444444, 1,32'h204,0,32'h0,32'h0));
        tbl.push_back(mk(0,0,32'h0,1,0,32'h0,         0,32'hFFFFFFFC,0,32'h0,32'h0));
        tbl.push_back(mk(0,0,32'h0,1,1,32'h55555555,  1,32'hFFFFFFFC,0,32'h0,32'h0));
        tbl.push_back(mk(0,0,32'h0,1,0,32'h0,         0,32'h0,1,32'hFFFFFFFC,32'h55555555));
        tbl.push_back(mk(0,1,32'h300,1,0,32'h0,       1,32'h0,0,32'h0,32'h0));
        tbl.push_back(mk(0,1,32'h400,1,1,32'h66666666, 1,32'h300,0,32'h0,32'h0));
        tbl.push_back(mk(0,0,32'h0,1,0,32'h0,         0,32'h400,0,32'h0,32'h0));
        tbl.push_back(mk(0,0,32'h0,1,0,32'h0,         1,32'h400,0,32'h0,32'h0));
        tbl.push_back(mk(1,0,32'h0,1,0,32'h0,         0,32'h0,0,32'h0,32'h0));
        tbl.push_back(mk(0,0,32'h0,1,1,32'h77777777,  0,32'h0,0,32'h0,32'h0));
        tbl.push_back(mk(0,0,32'h0,1,0,32'h0,         1,32'h0,0,32'h0,32'h0));
        tbl.push_back(mk(0,0,32'h0,1,0,32'h0,         1,32'h0,0,32'h0,32'h0));

        rst = 1'b1; redirect = 1'b0; redirect_pc = '0;
        id_ready = 1'b1; imem_ack = 1'b0; imem_rdata = '0;

        // Inputs change at negedge; outputs are checked 1 time unit later, before the next rising edge.
        foreach (tbl[i]) begin
            @(negedge clk);
            rst         = tbl[i].rst;
            redirect    = tbl[i].redir;
            redirect_pc = tbl[i].rpc;
            id_ready    = tbl[i].idr;
            imem_ack    = tbl[i].ack;
            imem_rdata  = tbl[i].rdata;
            #1;
            check_out($sformatf("row%0d", i), tbl[i].req, tbl[i].addr, tbl[i].v,
                      tbl[i].pc, tbl[i].instr);
        end

        // Reset asserted shortly after a rising edge while a request is waiting.
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_out("async_rst", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);

        // Zero-wait memory: validF two edges after reset release.
        @(negedge clk);
        rst = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h13; id_ready = 1'b0;
        #1;
        check_out("lat_e0", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        @(negedge clk); #1;
        check_out("lat_e1", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0);
        @(negedge clk); #1;
        check_out("lat_e2", 1'b0, 32'h4, 1'b1, 32'h0, 32'h13);

        // Streaming with decode always ready: one instruction every two cycles.
        id_ready = 1'b1;
        mv = 1'b1; mreq = 1'b0; maddr = 32'h4; mpc = 32'h0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk); #1;
            if (mv) begin
                mv = 1'b0; mreq = 1'b1;
            end else begin
                mv = 1'b1; mreq = 1'b0; mpc = maddr; maddr = maddr + 32'd4;
            end
            check_out($sformatf("stream%0d", k), mreq, maddr, mv,
                      mv ? mpc : 32'h0, mv ? 32'h13 : 32'h0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
